// File: rtl/aurora_tx_lane_ctrl.sv
// Aurora TX lane controller: picks the character and K flag fed to the 8b10b encoder.
// Sequence: comma init, then user data or idles; optional clock compensation (AURORA_TX_CC_EN).
//
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   reinit_i       : synchronous restart of lane initialisation
//   s_data_i       : user byte
//   s_valid_i      : user byte valid
//   s_ready_o      : byte accepted this cycle (decoded from registers only)
//   data_o         : character to encoder
//   ctrl_o         : 1 = K character, 0 = D character
//   lane_up_o      : initialisation done, lane in service
//
// Build option: define AURORA_TX_CC_EN to include the CC timer, the CC state
// and the forced idle that precedes each CC sequence.

module aurora_tx_lane_ctrl #(
  parameter int INIT_CNT  = 64,
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       reinit_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  output logic [7:0] data_o,
  output logic       ctrl_o,
  output logic       lane_up_o
);

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    CC   = 2'd2
  } state_t;

  localparam int IW =
    (INIT_CNT > 1) ? $clog2(INIT_CNT) : 1;
  localparam logic [IW-1:0] INIT_LAST =
    IW'(INIT_CNT - 1);

  state_t        state;
  logic [IW-1:0] init_cnt;
  logic          take;

`ifdef AURORA_TX_CC_EN
  localparam logic [7:0] K23_7 = 8'hF7;

  localparam int TW =
    (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam int LW =
    (CC_LEN > 1) ? $clog2(CC_LEN) : 1;
  localparam logic [TW-1:0] TIMER_LAST =
    TW'(CC_PERIOD - 1);
  localparam logic [LW-1:0] CC_LAST =
    LW'(CC_LEN - 1);

  logic [TW-1:0] cc_timer;
  logic [LW-1:0] cc_cnt;
  logic          cc_slot;

  // Last RUN cycle of the interval: no acceptance,
  // a forced idle goes out ahead of the CC burst.
  assign cc_slot =
    (state == RUN) && (cc_timer == TIMER_LAST);
  assign s_ready_o = (state == RUN) && !cc_slot;
`else
  assign s_ready_o = (state == RUN);
`endif

  assign take = s_valid_i && s_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= INIT;
      init_cnt  <= '0;
      data_o    <= K28_5;
      ctrl_o    <= 1'b1;
      lane_up_o <= 1'b0;
`ifdef AURORA_TX_CC_EN
      cc_timer  <= '0;
      cc_cnt    <= '0;
`endif
    end else if (reinit_i) begin
      // A beat handshaken alongside reinit is
      // still sent; everything else restarts.
      state     <= INIT;
      init_cnt  <= '0;
      lane_up_o <= 1'b0;
`ifdef AURORA_TX_CC_EN
      cc_timer  <= '0;
      cc_cnt    <= '0;
`endif
      if (take) begin
        data_o <= s_data_i;
        ctrl_o <= 1'b0;
      end else begin
        data_o <= K28_5;
        ctrl_o <= 1'b1;
      end
    end else begin
      case (state)
        INIT: begin
          data_o <= K28_5;
          ctrl_o <= 1'b1;
          if (init_cnt == INIT_LAST) begin
            state     <= RUN;
            init_cnt  <= '0;
            lane_up_o <= 1'b1;
`ifdef AURORA_TX_CC_EN
            cc_timer  <= '0;
`endif
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        RUN: begin
`ifdef AURORA_TX_CC_EN
          if (cc_slot) begin
            data_o   <= K28_5;
            ctrl_o   <= 1'b1;
            state    <= CC;
            cc_timer <= '0;
            cc_cnt   <= '0;
          end else begin
            cc_timer <= cc_timer + 1'b1;
            if (take) begin
              data_o <= s_data_i;
              ctrl_o <= 1'b0;
            end else begin
              data_o <= K28_5;
              ctrl_o <= 1'b1;
            end
          end
`else
          if (take) begin
            data_o <= s_data_i;
            ctrl_o <= 1'b0;
          end else begin
            data_o <= K28_5;
            ctrl_o <= 1'b1;
          end
`endif
        end
`ifdef AURORA_TX_CC_EN
        CC: begin
          data_o <= K23_7;
          ctrl_o <= 1'b1;
          if (cc_cnt == CC_LAST) begin
            state  <= RUN;
            cc_cnt <= '0;
          end else begin
            cc_cnt <= cc_cnt + 1'b1;
          end
        end
`endif
        default: begin
          state    <= INIT;
          init_cnt <= '0;
          data_o   <= K28_5;
          ctrl_o   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aurora_tx_lane_ctrl.sv
// Directed bench for aurora_tx_lane_ctrl (INIT_CNT=4, CC_PERIOD=16, CC_LEN=4).
// CC scenarios apply when AURORA_TX_CC_EN is defined; otherwise the no-CC behaviour is checked.

module tb_aurora_tx_lane_ctrl;

  localparam int INIT_N = 4;
  localparam int PER    = 16;
  localparam int CLEN   = 4;
`ifdef AURORA_TX_CC_EN
  localparam bit CC_ON = 1'b1;
`else
  localparam bit CC_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       reinit;
  logic [7:0] sdata;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       ctrl;
  logic       lane_up;

  int n_chk  = 0;
  int n_fail = 0;

  aurora_tx_lane_ctrl #(
    .INIT_CNT (INIT_N),
    .CC_PERIOD(PER),
    .CC_LEN   (CLEN)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .reinit_i (reinit),
    .s_data_i (sdata),
    .s_valid_i(valid),
    .s_ready_o(ready),
    .data_o   (data),
    .ctrl_o   (ctrl),
    .lane_up_o(lane_up)
  );

  always #5 clk = ~clk;

  // Observed vector: {data, ctrl, lane_up, ready}
  task automatic test_reset;
    logic [10:0] exp;
    logic        lu;
    rst_n  = 1'b0;
    reinit = 1'b0;
    valid  = 1'b0;
    sdata  = 8'h00;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({data, ctrl, lane_up, ready} !== {8'hBC, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_vals got=%h want=%h",
               {data, ctrl, lane_up, ready}, {8'hBC, 1'b1, 1'b0, 1'b0});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= INIT_N; k++) begin
      @(negedge clk);
      lu  = (k == INIT_N);
      exp = {8'hBC, 1'b1, lu, lu};
      n_chk++;
      if ({data, ctrl, lane_up, ready} !== exp) begin
        n_fail++;
        $display("FAIL init_seq k=%0d got=%h want=%h",
                 k, {data, ctrl, lane_up, ready}, exp);
      end
    end
  endtask

  // Continuous valid from the first RUN cycle; CC builds see
  // 15 data + forced idle + 4 CC every 20 cycles.
  task automatic test_stream;
    int          nxt;
    int          ncyc;
    int          p;
    logic        exp_r;
    logic [8:0]  exp_dk;
    nxt   = 0;
    ncyc  = CC_ON ? 60 : 100;
    valid = 1'b1;
    sdata = 8'h00;
    for (int c = 0; c < ncyc; c++) begin
      p     = c % (PER + CLEN);
      exp_r = CC_ON ? (p < PER - 1) : 1'b1;
      n_chk++;
      if (ready !== exp_r) begin
        n_fail++;
        $display("FAIL stream_ready c=%0d got=%b want=%b", c, ready, exp_r);
      end
      @(negedge clk);
      if (exp_r) begin
        exp_dk = {nxt[7:0], 1'b0};
        nxt++;
        sdata = nxt[7:0];
      end else if (p == PER - 1) begin
        exp_dk = {8'hBC, 1'b1};
      end else begin
        exp_dk = {8'hF7, 1'b1};
      end
      n_chk++;
      if ({data, ctrl, lane_up} !== {exp_dk, 1'b1}) begin
        n_fail++;
        $display("FAIL stream_data c=%0d got=%h want=%h",
                 c, {data, ctrl, lane_up}, {exp_dk, 1'b1});
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_reinit_run;
    logic [10:0] exp;
    logic        lu;
    n_chk++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reinit_run_pre got=%b want=1", ready);
    end
    valid  = 1'b1;
    sdata  = 8'hA5;
    reinit = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({data, ctrl, lane_up, ready} !== {8'hA5, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reinit_run_beat got=%h want=%h",
               {data, ctrl, lane_up, ready}, {8'hA5, 1'b0, 1'b0, 1'b0});
    end
    valid  = 1'b0;
    reinit = 1'b0;
    for (int k = 1; k <= INIT_N; k++) begin
      @(negedge clk);
      lu  = (k == INIT_N);
      exp = {8'hBC, 1'b1, lu, lu};
      n_chk++;
      if ({data, ctrl, lane_up, ready} !== exp) begin
        n_fail++;
        $display("FAIL reinit_run_init k=%0d got=%h want=%h",
                 k, {data, ctrl, lane_up, ready}, exp);
      end
    end
  endtask

`ifdef AURORA_TX_CC_EN
  task automatic test_reinit_cc;
    logic [10:0] exp;
    logic        lu;
    logic        r;
    valid = 1'b0;
    for (int c = 0; c < PER; c++) begin
      @(negedge clk);
      r   = (c < PER - 2);
      exp = {8'hBC, 1'b1, 1'b1, r};
      n_chk++;
      if ({data, ctrl, lane_up, ready} !== exp) begin
        n_fail++;
        $display("FAIL cc_idle c=%0d got=%h want=%h",
                 c, {data, ctrl, lane_up, ready}, exp);
      end
    end
    @(negedge clk);
    n_chk++;
    if ({data, ctrl, lane_up, ready} !== {8'hF7, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL cc_first got=%h want=%h",
               {data, ctrl, lane_up, ready}, {8'hF7, 1'b1, 1'b1, 1'b0});
    end
    reinit = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({data, ctrl, lane_up, ready} !== {8'hBC, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL cc_abort got=%h want=%h",
               {data, ctrl, lane_up, ready}, {8'hBC, 1'b1, 1'b0, 1'b0});
    end
    reinit = 1'b0;
    for (int k = 1; k <= INIT_N; k++) begin
      @(negedge clk);
      lu  = (k == INIT_N);
      exp = {8'hBC, 1'b1, lu, lu};
      n_chk++;
      if ({data, ctrl, lane_up, ready} !== exp) begin
        n_fail++;
        $display("FAIL cc_reinit_init k=%0d got=%h want=%h",
                 k, {data, ctrl, lane_up, ready}, exp);
      end
    end
  endtask
`endif

  task automatic test_reinit_hold;
    logic [10:0] exp;
    logic        lu;
    reinit = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_chk++;
      if ({data, ctrl, lane_up, ready} !== {8'hBC, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reinit_hold k=%0d got=%h want=%h",
                 k, {data, ctrl, lane_up, ready}, {8'hBC, 1'b1, 1'b0, 1'b0});
      end
    end
    reinit = 1'b0;
    for (int k = 1; k <= INIT_N; k++) begin
      @(negedge clk);
      lu  = (k == INIT_N);
      exp = {8'hBC, 1'b1, lu, lu};
      n_chk++;
      if ({data, ctrl, lane_up, ready} !== exp) begin
        n_fail++;
        $display("FAIL reinit_hold_init k=%0d got=%h want=%h",
                 k, {data, ctrl, lane_up, ready}, exp);
      end
    end
  endtask

  task automatic test_async_reset;
    logic [10:0] exp;
    logic        lu;
    valid = 1'b1;
    sdata = 8'h3C;
    @(negedge clk);
    n_chk++;
    if ({data, ctrl, lane_up, ready} !== {8'h3C, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL async_pre got=%h want=%h",
               {data, ctrl, lane_up, ready}, {8'h3C, 1'b0, 1'b1, 1'b1});
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({data, ctrl, lane_up, ready} !== {8'hBC, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_rst got=%h want=%h",
               {data, ctrl, lane_up, ready}, {8'hBC, 1'b1, 1'b0, 1'b0});
    end
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= INIT_N; k++) begin
      @(negedge clk);
      lu  = (k == INIT_N);
      exp = {8'hBC, 1'b1, lu, lu};
      n_chk++;
      if ({data, ctrl, lane_up, ready} !== exp) begin
        n_fail++;
        $display("FAIL async_init k=%0d got=%h want=%h",
                 k, {data, ctrl, lane_up, ready}, exp);
      end
    end
    valid = 1'b1;
    sdata = 8'h5A;
    @(negedge clk);
    valid = 1'b0;
    n_chk++;
    if ({data, ctrl, lane_up, ready} !== {8'h5A, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL async_first_byte got=%h want=%h",
               {data, ctrl, lane_up, ready}, {8'h5A, 1'b0, 1'b1, 1'b1});
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_reinit_run();
`ifdef AURORA_TX_CC_EN
    test_reinit_cc();
`endif
    test_reinit_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
